uart_rx_unit: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_unit.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by the receiver and transmitter.
//               Contents:
//               - the receiver state encoding;
//               - the default bit timing and frame width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DATA_LENGTH_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line.
//               Both flops reset to 1 so that a reset looks like an idle line
//               and cannot be mistaken for a start bit.
// Ports       : clk_i   - system clock
//               rst_i   - synchronous active-high reset
//               async_i - asynchronous serial input
//               sync_o  - synchronized serial line
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_unit
// Description : Asynchronous serial receiver, LSB first, idle-high line,
//               mid-bit sampling from a fixed clocks-per-bit count.
//               Default frame 8N1. Defining UART_RX_PARITY_EN adds an even
//               parity bit (8E1); a parity mismatch pulses o_error and the
//               byte is discarded.
// Ports       : i_clk           - system clock
//               i_rst           - synchronous active-high reset
//               i_RX_bit        - asynchronous serial line, idle high
//               o_Received_byte - last correctly framed byte
//               o_receive_state - high while a frame is being handled
//               o_RX_done       - one-cycle pulse on an accepted frame
//               o_error         - one-cycle pulse on framing/parity error
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_LENGTH  = DATA_LENGTH_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_RX_bit,
  output logic [DATA_LENGTH-1:0] o_Received_byte,
  output logic                   o_receive_state,
  output logic                   o_RX_done,
  output logic                   o_error
);

  localparam int CNT_W = 16;
  localparam int IDX_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LENGTH - 1);

  logic rx_s;

  rx_state_e              state_q,   state_d;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic [DATA_LENGTH-1:0] shift_q,   shift_d;
  logic [DATA_LENGTH-1:0] byte_q,    byte_d;
  logic                   done_q,    done_d;
  logic                   err_q,     err_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q, par_err_d;
`endif

  uart_rx_sync u_sync (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .async_i (i_RX_bit),
    .sync_o  (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      // Re-check the start bit at its centre; a line that has gone high
      // again was only a glitch.
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          idx_d     = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Counting a full bit from the start-bit centre lands on data centres.
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d      = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: data bits plus parity bit hold an even number of ones.
      PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_err_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            // Low stop bit: wait out the held-low line before re-arming.
            err_d   = 1'b1;
            state_d = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_Received_byte = byte_q;
  assign o_receive_state = (state_q != IDLE);
  assign o_RX_done       = done_q;
  assign o_error         = err_q;

endmodule : uart_rx_unit
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_unit
// Description : Self-checking bench for uart_rx_unit. A serial driver builds
//               frames bit by bit and records the expected outcome of each
//               frame in a scoreboard queue; an independent monitor pops an
//               entry whenever the receiver pulses done or error.
//               Compile with +define+UART_RX_PARITY_EN to exercise 8E1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_unit;

  localparam int CPB = 434;
  localparam int DL  = 8;

  logic          i_clk    = 1'b0;
  logic          i_rst    = 1'b1;
  logic          i_RX_bit = 1'b1;
  logic [DL-1:0] o_Received_byte;
  logic          o_receive_state;
  logic          o_RX_done;
  logic          o_error;

  uart_rx_unit #(
    .CLKS_PER_BIT (CPB),
    .DATA_LENGTH  (DL)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_RX_bit        (i_RX_bit),
    .o_Received_byte (o_Received_byte),
    .o_receive_state (o_receive_state),
    .o_RX_done       (o_RX_done),
    .o_error         (o_error)
  );

  always #10 i_clk = ~i_clk;

  typedef struct {
    bit            is_err;
    logic [DL-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks     = 0;
  int            errors     = 0;
  logic [DL-1:0] model_byte = '0;
  int            rs_cnt     = 0;
  logic          rs_prev    = 1'b0;

  // Monitor: every output pulse must match the oldest outstanding frame.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_RX_done || o_error) begin
      checks++;
      if (o_RX_done && o_error) begin
        errors++;
        $display("FAIL done_and_error actual=both_high required=exclusive");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual done=%0b err=%0b required=no_pulse",
                 o_RX_done, o_error);
      end else begin
        e = sb.pop_front();
        checks++;
        if (o_error !== e.is_err) begin
          errors++;
          $display("FAIL pulse_kind actual err=%0b required err=%0b", o_error, e.is_err);
        end
        checks++;
        if (o_Received_byte !== e.data) begin
          errors++;
          $display("FAIL pulse_byte actual=%02h required=%02h", o_Received_byte, e.data);
        end
      end
    end
    // Length of the most recent busy window, in clocks.
    if (o_receive_state) begin
      if (!rs_prev) rs_cnt = 0;
      rs_cnt++;
    end
    rs_prev = o_receive_state;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic line(input logic b, input int n);
    i_RX_bit = b;
    repeat (n) @(negedge i_clk);
  endtask

  // Drive one frame. good_stop=0 holds the line low for three bit periods
  // from the stop bit onward; par_bad inverts the parity bit.
  task automatic send_frame(input logic [DL-1:0] d, input bit good_stop,
                            input bit par_bad, input int per);
    exp_t e;
    e.is_err = !good_stop || par_bad;
    e.data   = e.is_err ? model_byte : d;
    if (!e.is_err) model_byte = d;
    sb.push_back(e);
    line(1'b0, per);
    for (int i = 0; i < DL; i++) line(d[i], per);
`ifdef UART_RX_PARITY_EN
    line((^d) ^ par_bad, per);
`endif
    if (good_stop) begin
      line(1'b1, per);
    end else begin
      line(1'b0, 3 * per);
      line(1'b1, per);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2 * CPB && sb.size() != 0; i++) @(negedge i_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual pending=%0d required=0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (150_000) @(negedge i_clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DL-1:0] d;
    logic [DL-1:0] partial;
    bit            good;
    bit            pb;
    int            per;

    repeat (3) @(negedge i_clk);
    check("rst_byte",  o_Received_byte, 0);
    check("rst_state", o_receive_state, 0);
    check("rst_done",  o_RX_done, 0);
    check("rst_error", o_error, 0);
    i_rst = 1'b0;
    line(1'b1, CPB);

    // Single frame and busy-window length (about ten bit periods).
    send_frame(8'h31, 1'b1, 1'b0, CPB);
    drain("f31");
    check("f31_byte", o_Received_byte, 8'h31);
    check("f31_busy_len", (rs_cnt >= 9 * CPB && rs_cnt <= 10 * CPB), 1);
    check("f31_idle", o_receive_state, 0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, CPB);
    send_frame(8'hFF, 1'b1, 1'b0, CPB);
    drain("b2b");
    check("b2b_byte", o_Received_byte, 8'hFF);
    line(1'b1, CPB);

    // Short low glitch is rejected.
    line(1'b0, 100);
    line(1'b1, 2 * CPB);
    check("glitch_state", o_receive_state, 0);
    check("glitch_byte", o_Received_byte, 8'hFF);

    // Framing error followed by a long low line, then a good frame.
    send_frame(8'hA5, 1'b0, 1'b0, CPB);
    drain("brk");
    check("brk_byte", o_Received_byte, 8'hFF);
    check("brk_idle", o_receive_state, 0);
    send_frame(8'h5A, 1'b1, 1'b0, CPB);
    drain("f5a");
    check("f5a_byte", o_Received_byte, 8'h5A);
    line(1'b1, CPB);

    // Reset in the middle of data bit 3.
    partial = 8'hC3;
    line(1'b0, CPB);
    for (int i = 0; i < 3; i++) line(partial[i], CPB);
    line(partial[3], CPB / 2);
    i_rst    = 1'b1;
    i_RX_bit = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_byte = '0;
    check("mrst_byte",  o_Received_byte, 0);
    check("mrst_state", o_receive_state, 0);
    check("mrst_done",  o_RX_done, 0);
    check("mrst_error", o_error, 0);
    line(1'b1, 2 * CPB);
    send_frame(8'h7E, 1'b1, 1'b0, CPB);
    drain("f7e");
    check("f7e_byte", o_Received_byte, 8'h7E);

`ifdef UART_RX_PARITY_EN
    line(1'b1, CPB);
    send_frame(8'h31, 1'b1, 1'b0, CPB);
    drain("par_ok");
    check("par_ok_byte", o_Received_byte, 8'h31);
    send_frame(8'h31, 1'b1, 1'b1, CPB);
    drain("par_bad");
    check("par_bad_byte", o_Received_byte, 8'h31);
`endif

    // Random frames with a small per-frame baud offset (about +-1.4%).
    for (int n = 0; n < 5; n++) begin
      d    = DL'($urandom);
      good = ($urandom_range(0, 3) != 0);
      per  = CPB - 6 + int'($urandom_range(0, 12));
      pb   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pb   = ($urandom_range(0, 3) == 0);
`endif
      send_frame(d, good, pb, per);
      drain("rnd");
      check("rnd_byte", o_Received_byte, model_byte);
      line(1'b1, int'($urandom_range(0, 1)) * per);
    end

    line(1'b1, CPB);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_unit
`default_nettype wire
